// File: rtl/sipo_deframer_pkg.sv
// Shared definitions for the serial-in parallel-out deframer:
// FSM state encoding and a ceiling-log2 helper used to size the bit counter.
package sipo_deframer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Number of bits needed to hold values 0 .. value-1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter. Assembles WIDTH serial bits into a word
// and flags, combinationally, the cycle whose rising edge accepts the last bit.
module sipo_shift_core
   import sipo_deframer_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             res,
   input  logic             sin_i,
   input  logic             start_i,  // accept sin_i as the first bit of a new word
   input  logic             step_i,   // accept sin_i as the next bit of the current word
   output logic [WIDTH-1:0] word_o,   // word including the bit accepted this edge
   output logic             done_o    // this edge accepts the WIDTH-th bit
);

   localparam int CW = clog2(WIDTH + 1);

   logic [WIDTH-1:0] sh_q, sh_d, sh_next;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_next;

   // Next shift value and count; a start discards any partial word.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      sh_next  = sh_q;
      cnt_next = cnt_q;
      if (start_i) begin
         if (MSB_FIRST) sh_next = {{(WIDTH-1){1'b0}}, sin_i};
         else           sh_next = {sin_i, {(WIDTH-1){1'b0}}};
         cnt_next = CW'(1);
      end else if (step_i) begin
         if (MSB_FIRST) sh_next = {sh_q[WIDTH-2:0], sin_i};
         else           sh_next = {sin_i, sh_q[WIDTH-1:1]};
         cnt_next = cnt_q + CW'(1);
      end
      done_o = (start_i || step_i) && (cnt_next == CW'(WIDTH));
      word_o = sh_next;
      sh_d   = sh_next;
      cnt_d  = done_o ? '0 : cnt_next;
   end

   // Shift register and counter state.
   always_ff @(posedge clk or posedge res) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (res) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sipo_deframer.sv
// Serial deframer: waits for a start-of-frame marker, assembles a WIDTH-bit
// word, and hands it to the consumer through a one-entry ready/valid buffer
// with a sticky overrun flag for words dropped while the buffer is full.
module sipo_deframer
   import sipo_deframer_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             res,
   input  logic             sin,
   input  logic             sin_en,
   input  logic             sof,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   input  logic             clr_ovr,
   output logic             overrun,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;

   logic             start, step, done;
   logic [WIDTH-1:0] word;

   // A marked bit always starts a new word; unmarked bits count only mid-word.
   assign start = sin_en && sof;
   assign step  = sin_en && !sof && (state_q == SHIFT);

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk     (clk),
      .res     (res),
      .sin_i   (sin),
      .start_i (start),
      .step_i  (step),
      .word_o  (word),
      .done_o  (done)
   );

   // Next state, output buffer and overrun decisions.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      valid_d = valid_q;
      ovr_d   = ovr_q && !clr_ovr;

      if (done)       state_d = IDLE;
      else if (start) state_d = SHIFT;

      if (done) begin
         if (!valid_q || q_ready) begin
            q_d     = word;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;  // overrides a simultaneous clear
         end
      end else if (valid_q && q_ready) begin
         valid_d = 1'b0;
      end
   end

   // FSM, buffer and flag registers.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= IDLE;
         q_q     <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign q       = q_q;
   assign q_valid = valid_q;
   assign overrun = ovr_q;
   assign busy    = (state_q == SHIFT);

endmodule
